// File: rtl/siso_shift_ctrl_pkg.sv
// Shared definitions for the SISO shift-register transaction controller:
// FSM state type, default geometry and the transaction counter width.
package siso_ctrl_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } siso_ctrl_state_t;

    // The counter must reach WIDTH+DEPTH without wrapping.
    function automatic int cnt_width(input int width, input int depth);
        return $clog2(width + depth + 1);
    endfunction

endpackage

// File: rtl/siso_shift_ctrl_if.sv
// Bundles the parallel handshakes and the serial link to the external SISO
// register. The err signal exists only when SISO_CTRL_CHECK_EN is defined.
//
// Handshake rule (both parallel channels): a word moves on a rising edge where
// valid && ready are both high; a producer holding valid keeps its data
// stable, and ready never depends combinationally on valid.
interface siso_shift_ctrl_if
    import siso_ctrl_pkg::*;
    #(parameter int WIDTH = DEF_WIDTH);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             si;
    logic             shift_en;
    logic             q;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
`ifdef SISO_CTRL_CHECK_EN
    logic             err;
`endif

    // Controller side.
    modport master (
        input  in_valid, in_data, q, out_ready,
`ifdef SISO_CTRL_CHECK_EN
        output err,
`endif
        output in_ready, si, shift_en, out_valid, out_data
    );

    // Environment side: word source, word sink and the SISO register.
    modport slave (
        output in_valid, in_data, q, out_ready,
`ifdef SISO_CTRL_CHECK_EN
        input  err,
`endif
        input  in_ready, si, shift_en, out_valid, out_data
    );

endinterface

// File: rtl/siso_shift_ctrl.sv
// Transaction controller for a DEPTH-stage serial-in/serial-out register.
// Accepts a parallel word, shifts it out MSB-first on si with shift_en high,
// keeps shifting zeros for DEPTH more edges to drain the register, and
// reassembles the returning q bits into out_data.
// Optional loopback self-check: define SISO_CTRL_CHECK_EN to get the err
// output, which flags a returned word that differs from the one sent.
module siso_shift_ctrl
    import siso_ctrl_pkg::*;
    #(
        parameter int WIDTH = DEF_WIDTH,
        parameter int DEPTH = DEF_DEPTH
    )
    (
        input  logic                clk,
        input  logic                rst,
        siso_shift_ctrl_if.master   bus,
        output siso_ctrl_state_t    dbg_state_o
    );

    localparam int CW = cnt_width(WIDTH, DEPTH);

    // cnt holds the number of enabled edges already taken in this
    // transaction, so before enabled edge k it reads k-1.
    localparam logic [CW-1:0] LAST_SHIFT = CW'(WIDTH - 1);
    localparam logic [CW-1:0] LAST_EDGE  = CW'(WIDTH + DEPTH - 1);
    // Edges 1..DEPTH only flush stale register contents; capture starts at
    // edge DEPTH+1, when the first sent bit arrives on q.
    localparam logic [CW-1:0] FIRST_CAP  = CW'(DEPTH);

    siso_ctrl_state_t state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] tx_q, tx_d;
    logic [WIDTH-1:0] rx_q, rx_d;
    logic             capture;
`ifdef SISO_CTRL_CHECK_EN
    logic [WIDTH-1:0] exp_q, exp_d;
    logic             err_q, err_d;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Counter, transmit/receive shift registers and the optional checker.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            tx_q  <= '0;
            rx_q  <= '0;
`ifdef SISO_CTRL_CHECK_EN
            exp_q <= '0;
            err_q <= 1'b0;
`endif
        end else begin
            cnt_q <= cnt_d;
            tx_q  <= tx_d;
            rx_q  <= rx_d;
`ifdef SISO_CTRL_CHECK_EN
            exp_q <= exp_d;
            err_q <= err_d;
`endif
        end
    end

    // Next-state and datapath decode.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
`ifdef SISO_CTRL_CHECK_EN
        exp_d   = exp_q;
        err_d   = err_q;
`endif
        capture = (state_q == SHIFT || state_q == DRAIN) && (cnt_q >= FIRST_CAP);

        // Capture may already begin in SHIFT when DEPTH < WIDTH.
        if (capture) begin
            rx_d = WIDTH'({rx_q, bus.q});
        end

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    tx_d    = bus.in_data;
                    cnt_d   = '0;
                    state_d = SHIFT;
`ifdef SISO_CTRL_CHECK_EN
                    exp_d   = bus.in_data;
`endif
                end
            end
            SHIFT: begin
                tx_d  = tx_q << 1;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST_SHIFT) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST_EDGE) begin
                    state_d = DONE;
`ifdef SISO_CTRL_CHECK_EN
                    // Compare the final captured word, not the stale rx_q.
                    err_d   = (rx_d != exp_q);
`endif
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
`ifdef SISO_CTRL_CHECK_EN
                    err_d   = 1'b0;
`endif
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs decoded from registered state only.
    always_comb begin
        bus.in_ready  = (state_q == IDLE);
        bus.shift_en  = (state_q == SHIFT) || (state_q == DRAIN);
        bus.si        = (state_q == SHIFT) ? tx_q[WIDTH-1] : 1'b0;
        bus.out_valid = (state_q == DONE);
        bus.out_data  = (state_q == DONE) ? rx_q : '0;
`ifdef SISO_CTRL_CHECK_EN
        bus.err       = err_q;
`endif
    end

    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_siso_shift_ctrl.sv
// Directed bench for siso_shift_ctrl with a DEPTH-stage enable-gated SISO
// register model on the serial side. Define SISO_CTRL_CHECK_EN to include
// the loopback-check scenario.
module tb_siso_shift_ctrl;
    import siso_ctrl_pkg::*;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int NEDGE = WIDTH + DEPTH;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    siso_ctrl_state_t dbg_state;
    siso_shift_ctrl_if #(.WIDTH(WIDTH)) bus ();

    siso_shift_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .dbg_state_o (dbg_state)
    );

    int checks = 0;
    int errors = 0;
    logic [WIDTH-1:0] exp_q[$];

    // ---------------- SISO register model ----------------
    // Starts full of ones so the first transaction must flush stale data.
    logic [DEPTH-1:0] sr = '1;
    int               edge_cnt = 0;
    logic             corrupt = 1'b0;

    always @(posedge clk) begin
        if (bus.shift_en) begin
            sr       <= {sr[DEPTH-2:0], bus.si};
            edge_cnt <= edge_cnt + 1;
        end else begin
            edge_cnt <= 0;
        end
    end

    // When corrupt is set, the bit captured on enabled edge DEPTH+3 is inverted.
    assign bus.q = sr[DEPTH-1] ^ (corrupt && (edge_cnt == DEPTH + 2));

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a word and return just after its accept edge.
    task automatic accept_word(input logic [WIDTH-1:0] d);
        int n = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        while (!bus.in_ready && n < 50) begin
            tick();
            n++;
        end
        checks++;
        if (!bus.in_ready) begin
            errors++;
            $display("FAIL accept_timeout: in_ready=%b required 1", bus.in_ready);
        end
        tick();
        bus.in_valid = 1'b0;
        bus.in_data  = ~d;
    endtask

    // Wait (bounded) for out_valid, counting cycles and shift_en-high cycles.
    task automatic wait_result(output int cyc, output int en);
        cyc = 0;
        en  = 0;
        while (!bus.out_valid && cyc < 40) begin
            if (bus.shift_en) en++;
            tick();
            cyc++;
        end
        checks++;
        if (!bus.out_valid) begin
            errors++;
            $display("FAIL result_timeout: out_valid=%b required 1", bus.out_valid);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst          = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h77;
        repeat (2) begin
            tick();
            checks++;
            if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %b want 1", bus.in_ready); end
            checks++;
            if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b want 0", bus.out_valid); end
            checks++;
            if (bus.si !== 1'b0) begin errors++; $display("FAIL rst_si: got %b want 0", bus.si); end
            checks++;
            if (bus.shift_en !== 1'b0) begin errors++; $display("FAIL rst_shift_en: got %b want 0", bus.shift_en); end
            checks++;
            if (bus.out_data !== 8'h00) begin errors++; $display("FAIL rst_out_data: got %h want 00", bus.out_data); end
`ifdef SISO_CTRL_CHECK_EN
            checks++;
            if (bus.err !== 1'b0) begin errors++; $display("FAIL rst_err: got %b want 0", bus.err); end
`endif
        end
        bus.in_valid = 1'b0;
        rst          = 1'b0;
        tick();
        checks++;
        if (dbg_state !== IDLE || bus.shift_en !== 1'b0) begin
            errors++;
            $display("FAIL rst_no_transfer: state=%0d shift_en=%b want IDLE/0", dbg_state, bus.shift_en);
        end
    endtask

    task automatic test_single_word();
        logic [WIDTH-1:0] w = 8'hA5;
        logic [WIDTH-1:0] e;
        exp_q.push_back(w);
        accept_word(w);
        for (int i = 0; i < WIDTH; i++) begin
            checks++;
            if (bus.si !== w[WIDTH-1-i] || bus.shift_en !== 1'b1) begin
                errors++;
                $display("FAIL single_si_bit%0d: si=%b shift_en=%b want %b/1", i, bus.si, bus.shift_en, w[WIDTH-1-i]);
            end
            tick();
        end
        for (int j = 0; j < DEPTH; j++) begin
            checks++;
            if (bus.si !== 1'b0 || bus.shift_en !== 1'b1 || bus.out_valid !== 1'b0) begin
                errors++;
                $display("FAIL single_drain%0d: si=%b shift_en=%b out_valid=%b want 0/1/0", j, bus.si, bus.shift_en, bus.out_valid);
            end
            tick();
        end
        e = exp_q.pop_front();
        checks++;
        if (bus.out_valid !== 1'b1 || bus.shift_en !== 1'b0 || bus.out_data !== e) begin
            errors++;
            $display("FAIL single_result: out_valid=%b shift_en=%b out_data=%h want 1/0/%h", bus.out_valid, bus.shift_en, bus.out_data, e);
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL single_release: out_valid=%b in_ready=%b want 0/1", bus.out_valid, bus.in_ready);
        end
    endtask

    task automatic test_backpressure();
        int cyc, en;
        logic [WIDTH-1:0] e;
        exp_q.push_back(8'hC3);
        accept_word(8'hC3);
        wait_result(cyc, en);
        checks++;
        if (cyc != NEDGE || en != NEDGE) begin
            errors++;
            $display("FAIL bp_latency: cycles=%0d enabled=%0d want %0d/%0d", cyc, en, NEDGE, NEDGE);
        end
        e = exp_q.pop_front();
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h11;
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== e || bus.in_ready !== 1'b0 || bus.shift_en !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold%0d: out_valid=%b out_data=%h in_ready=%b shift_en=%b want 1/%h/0/0",
                         k, bus.out_valid, bus.out_data, bus.in_ready, bus.shift_en, e);
            end
            tick();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        checks++;
        if (dbg_state !== IDLE || bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_release: state=%0d in_ready=%b out_valid=%b want IDLE/1/0", dbg_state, bus.in_ready, bus.out_valid);
        end
    endtask

    task automatic test_back_to_back();
        int t[2];
        logic [WIDTH-1:0] d[2];
        logic [WIDTH-1:0] e;
        int nout = 0;
        int nacc = 0;
        int cyc  = 0;
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'h00);
        bus.out_ready = 1'b1;
        while (nout < 2 && cyc < 80) begin
            if (bus.out_valid) begin
                t[nout] = cyc;
                d[nout] = bus.out_data;
                nout++;
            end
            if (bus.in_ready && nacc < 2) begin
                bus.in_valid = 1'b1;
                bus.in_data  = (nacc == 0) ? 8'hFF : 8'h00;
                nacc++;
            end else if (nacc == 2 && !bus.in_ready) begin
                bus.in_valid = 1'b0;
            end
            tick();
            cyc++;
        end
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        checks++;
        if (nout != 2) begin
            errors++;
            $display("FAIL b2b_count: outputs=%0d want 2", nout);
        end else begin
            for (int k = 0; k < 2; k++) begin
                e = exp_q.pop_front();
                checks++;
                if (d[k] !== e) begin
                    errors++;
                    $display("FAIL b2b_data%0d: got %h want %h", k, d[k], e);
                end
            end
            checks++;
            if (t[1] - t[0] != NEDGE + 2) begin
                errors++;
                $display("FAIL b2b_spacing: got %0d want %0d", t[1] - t[0], NEDGE + 2);
            end
        end
        exp_q.delete();
    endtask

    task automatic test_reset_mid();
        int seen = 0;
        int cyc, en;
        logic [WIDTH-1:0] e;
        accept_word(8'hFF);
        repeat (5) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (dbg_state !== IDLE || bus.in_ready !== 1'b1 || bus.shift_en !== 1'b0 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL midrst_state: state=%0d in_ready=%b shift_en=%b out_valid=%b want IDLE/1/0/0",
                     dbg_state, bus.in_ready, bus.shift_en, bus.out_valid);
        end
        repeat (20) begin
            if (bus.out_valid) seen++;
            tick();
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL midrst_no_output: out_valid cycles=%0d want 0", seen);
        end
        exp_q.push_back(8'h3C);
        accept_word(8'h3C);
        wait_result(cyc, en);
        e = exp_q.pop_front();
        checks++;
        if (bus.out_data !== e || cyc != NEDGE) begin
            errors++;
            $display("FAIL midrst_next: out_data=%h cycles=%0d want %h/%0d", bus.out_data, cyc, e, NEDGE);
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

`ifdef SISO_CTRL_CHECK_EN
    task automatic test_check_feature();
        int cyc, en;
        corrupt = 1'b1;
        accept_word(8'h96);
        wait_result(cyc, en);
        // Edge DEPTH+3 captures sent bit 2, which lands in out_data[5].
        checks++;
        if (bus.out_data !== 8'hB6 || bus.err !== 1'b1) begin
            errors++;
            $display("FAIL chk_bad: out_data=%h err=%b want B6/1", bus.out_data, bus.err);
        end
        corrupt = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        checks++;
        if (bus.err !== 1'b0) begin
            errors++;
            $display("FAIL chk_clear: err=%b want 0", bus.err);
        end
        accept_word(8'h5A);
        wait_result(cyc, en);
        checks++;
        if (bus.out_data !== 8'h5A || bus.err !== 1'b0) begin
            errors++;
            $display("FAIL chk_clean: out_data=%h err=%b want 5A/0", bus.out_data, bus.err);
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask
`endif

    // ---------------- sequence and report ----------------
    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        test_reset();
        test_single_word();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
`ifdef SISO_CTRL_CHECK_EN
        test_check_feature();
`endif
        repeat (2) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
